// File: rtl/core_biu_pmem_pkg.sv
// Shared types and constants for the BIU physical-memory responder.
// Widths match the core's XLEN and LSU write-mask definitions.
package core_biu_pmem_pkg;

  localparam int CORE_XLEN            = 32;
  localparam int CORE_LSU_WMASK_WIDTH = CORE_XLEN / 8;

  // The wait counter is 4 bits wide, so LATENCY can be at most 15
  localparam int PMEM_LAT_W       = 4;
  localparam int PMEM_MAX_LATENCY = (1 << PMEM_LAT_W) - 1;

  typedef enum logic [1:0] {
    PMEM_IDLE = 2'd0,
    PMEM_WAIT = 2'd1,
    PMEM_RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/core_biu_pmem_array.sv
// Byte-writable word array with one synchronous read/write port.
// On a read, rdata_o updates at the enabled edge; on a write, rdata_o holds its value.
module core_biu_pmem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] wmask_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < XLEN / 8; b++) begin
          if (wmask_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core_biu_pmem_slave.sv
// Physical-memory responder behind the BIU: one request at a time, programmable
// wait states, byte-masked stores and word loads, registered valid/ready response.
module core_biu_pmem_slave
  import core_biu_pmem_pkg::*;
#(
  parameter int              XLEN      = CORE_XLEN,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam int                    MASK_W   = XLEN / 8;
  localparam logic [XLEN-1:0]       SPAN     = XLEN'(4 * DEPTH);
  localparam logic [PMEM_LAT_W-1:0] LAT_INIT = PMEM_LAT_W'(LATENCY);

  if (LATENCY < 0 || LATENCY > PMEM_MAX_LATENCY) begin : g_bad_latency
    $error("core_biu_pmem_slave: LATENCY out of range");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("core_biu_pmem_slave: DEPTH must be a power of two");
  end

  pmem_state_e           state_q;
  logic [PMEM_LAT_W-1:0] cnt_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rd_sel_q;

  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [MASK_W-1:0]     wmask_q;
  logic                  wen_q;

  logic                  accept_w;
  logic                  access_w;
  logic                  err_w;
  logic [XLEN-1:0]       off_w;
  logic [IDX_W-1:0]      idx_w;
  logic [XLEN-1:0]       arr_rdata;

  assign accept_w = req_valid & req_ready_q;
  // Counter holds the wait cycles still to go; the WAIT edge that sees zero is ACCESS
  assign access_w = (state_q == PMEM_WAIT) && (cnt_q == '0);

  // Offset wraps for addresses below BASE_ADDR, so that case is checked explicitly
  assign off_w = addr_q - BASE_ADDR;
  assign err_w = (addr_q < BASE_ADDR) || (off_w >= SPAN);
  assign idx_w = off_w[IDX_W+1:2];

  // Captured request fields carry no reset; they are only consumed after a capture
  always_ff @(posedge clk) begin
    if (accept_w) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PMEM_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      case (state_q)
        PMEM_IDLE: begin
          if (accept_w) begin
            state_q     <= PMEM_WAIT;
            cnt_q       <= LAT_INIT;
            req_ready_q <= 1'b0;
          end
        end
        PMEM_WAIT: begin
          if (access_w) begin
            state_q     <= PMEM_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_w;
            rd_sel_q    <= ~wen_q & ~err_w;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PMEM_RESP: begin
          if (rsp_ready) begin
            state_q     <= PMEM_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= PMEM_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rd_sel_q    <= 1'b0;
        end
      endcase
    end
  end

  core_biu_pmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .en_i    (access_w & ~err_w),
    .we_i    (wen_q),
    .wmask_i (wmask_q),
    .idx_i   (idx_w),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // The array read register only changes at ACCESS, so gating it keeps the response stable
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_core_biu_pmem_slave.sv
// Directed bench for core_biu_pmem_slave: a LATENCY=1 instance driven from a vector
// table and a LATENCY=3 instance used for the reset-during-WAIT sequence.
module tb_core_biu_pmem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int          checks = 0;
  int          errors = 0;
  string       tag;

  always #5 clk = ~clk;

  core_biu_pmem_slave #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & ~sel),
    .req_ready (req_ready1),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready & ~sel),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  core_biu_pmem_slave #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid & sel),
    .req_ready (req_ready3),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready & sel),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3)
  );

  assign req_ready_m = sel ? req_ready3 : req_ready1;
  assign rsp_valid_m = sel ? rsp_valid3 : rsp_valid1;
  assign rsp_err_m   = sel ? rsp_err3   : rsp_err1;
  assign rsp_rdata_m = sel ? rsp_rdata3 : rsp_rdata1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // One complete transaction; hold = cycles of response backpressure before taking it
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wmask, input logic [31:0] exp_rdata,
                     input logic exp_err, input int hold, input int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    n = 0;
    while (!req_ready_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready_m), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_wmask = ~wmask;
    n = 0;
    while (!rsp_valid_m && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(1 + lat));
    chk("rdata", rsp_rdata_m, exp_rdata);
    chk("err", 32'(rsp_err_m), 32'(exp_err));
    chk("busy_ready", 32'(req_ready_m), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid_m), 32'd1);
      chk("hold_rdata", rsp_rdata_m, exp_rdata);
      chk("hold_ready", 32'(req_ready_m), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid_m), 32'd0);
    chk("post_rdata", rsp_rdata_m, 32'd0);
    chk("post_err", 32'(rsp_err_m), 32'd0);
    chk("post_ready", 32'(req_ready_m), 32'd1);
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0, 0};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 0};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0};
    vecs[5]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0};
    vecs[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0};
    vecs[7]  = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, 0};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 0};
    vecs[10] = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 0};
    vecs[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 0};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, 0};
    vecs[13] = '{1'b0, 32'h8000_0023, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 0};
    vecs[14] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 5};

    sel       = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wmask = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tag = "reset";
    chk("ready1", 32'(req_ready1), 32'd1);
    chk("valid1", 32'(rsp_valid1), 32'd0);
    chk("rdata1", rsp_rdata1, 32'd0);
    chk("err1", 32'(rsp_err1), 32'd0);
    chk("ready3", 32'(req_ready3), 32'd1);
    chk("valid3", 32'(rsp_valid3), 32'd0);

    for (int v = 0; v < 15; v++) begin
      tag = $sformatf("vec%0d", v);
      txn(vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wmask,
          vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].hold, 1);
    end

    sel = 1'b1;
    tag = "l3_store";
    txn(1'b1, 32'h8000_0040, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, 0, 3);

    tag = "l3_rst_wait";
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0040;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    chk("ready_before", 32'(req_ready3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("in_wait_ready", 32'(req_ready3), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready3), 32'd1);
    chk("rst_valid", 32'(rsp_valid3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_phantom_rsp", 32'(rsp_valid3), 32'd0);
    chk("idle_ready", 32'(req_ready3), 32'd1);

    tag = "l3_load_old";
    txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
